// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Holds the controller state encoding, the operand-width ceiling and the
// magnitude helper used when operands are captured.
package mult_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of a value already extended to MAX_WIDTH bits. In signed mode
    // a negative value is negated; the most-negative WIDTH-bit value extends to
    // a MAX_WIDTH negative number whose magnitude still fits in WIDTH unsigned bits.
    function automatic logic [MAX_WIDTH-1:0] abs_mag(input logic [MAX_WIDTH-1:0] value,
                                                     input logic                 sgn);
        if (sgn && value[MAX_WIDTH-1]) begin
            return ~value + MAX_WIDTH'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/mult_seq_datapath.sv
// Datapath: captures operand magnitudes, accumulates one partial product per step, negates at the end.
// Latency: driven by FSM strobes; one step per enabled cycle, WIDTH steps then one fix cycle.
// Backpressure: none internally; the controller only strobes load/step/fix when ena=1.
module mult_seq_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               last_step,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]     ma;
    logic [WIDTH-1:0]     mb;
    logic                 neg;
    logic [PW-1:0]        acc;
    logic [CW-1:0]        cnt;
    logic [MAX_WIDTH-1:0] a_ext;
    logic [MAX_WIDTH-1:0] b_ext;
    logic [PW-1:0]        addend;

    // Extend operands to the helper width: sign-extend in signed mode, zero-extend otherwise.
    always_comb begin
        a_ext = MAX_WIDTH'(a);
        b_ext = MAX_WIDTH'(b);
        if (sgn) begin
            a_ext = MAX_WIDTH'($signed(a));
            b_ext = MAX_WIDTH'($signed(b));
        end
    end

    // Partial product for the current bit position; acc is wide enough that no carry is lost.
    always_comb begin
        addend = PW'(ma) << cnt;
    end

    assign last_step = (cnt == CW'(WIDTH - 1));

    // Operand capture, shift-and-add steps and final sign fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma      <= '0;
            mb      <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (load) begin
            ma  <= WIDTH'(abs_mag(a_ext, sgn));
            mb  <= WIDTH'(abs_mag(b_ext, sgn));
            neg <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            if (mb[cnt]) begin
                acc <= acc + addend;
            end
            cnt <= cnt + CW'(1);
        end else if (fix) begin
            // product persists after the handshake until the next fix.
            product <= neg ? (~acc + PW'(1)) : acc;
        end
    end

endmodule

// File: rtl/mult_seq_shift_add.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement per operation.
// Latency: out_valid rises WIDTH+1 enabled cycles after the accept edge.
// Backpressure: in_ready only in IDLE; product held in DONE until out_ready; ena=0 freezes everything.
module mult_seq_shift_add
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    state_t state;
    state_t state_nxt;
    logic   load;
    logic   step;
    logic   fix;
    logic   last_step;

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath strobes and handshake outputs; nothing advances while ena=0.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (ena && in_valid) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (ena) begin
                    step = 1'b1;
                    if (last_step) begin
                        state_nxt = FIX;
                    end
                end
            end
            FIX: begin
                busy = 1'b1;
                if (ena) begin
                    fix       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // in_valid is ignored here; a new operand waits for the IDLE cycle.
                out_valid = 1'b1;
                if (ena && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    mult_seq_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .fix      (fix),
        .a        (a),
        .b        (b),
        .sgn      (sgn),
        .last_step(last_step),
        .product  (product)
    );

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Self-checking bench for mult_seq_shift_add at WIDTH=4 and WIDTH=8.
// Directed vector table plus hand-written backpressure, stall, collision and reset sequences.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_mult_seq_shift_add;

    localparam int TIMEOUT = 50;

    logic clk;
    logic rst_n;
    logic ena;

    logic       in_valid4, in_ready4, sgn4, out_valid4, out_ready4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] product4;

    logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sgn;
        logic [7:0] exp;
    } vec_t;

    mult_seq_shift_add #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .in_valid (in_valid4),
        .in_ready (in_ready4),
        .a        (a4),
        .b        (b4),
        .sgn      (sgn4),
        .out_valid(out_valid4),
        .out_ready(out_ready4),
        .product  (product4),
        .busy     (busy4)
    );

    mult_seq_shift_add #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .a        (a8),
        .b        (b8),
        .sgn      (sgn8),
        .out_valid(out_valid8),
        .out_ready(out_ready8),
        .product  (product8),
        .busy     (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Present operands while IDLE; returns just after the accept edge.
    task automatic start4(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts);
        a4 = ta;
        b4 = tb_v;
        sgn4 = ts;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid, bounded.
    task automatic wait4(output int lat);
        lat = 0;
        while (!out_valid4 && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack4();
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts,
                        output logic [7:0] prod, output int lat);
        start4(ta, tb_v, ts);
        wait4(lat);
        prod = product4;
        ack4();
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        output logic [15:0] prod, output int lat);
        a8 = ta;
        b8 = tb_v;
        sgn8 = ts;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        prod = product8;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
    endtask

    initial begin
        vec_t        vecs[10];
        logic [7:0]  p4;
        logic [15:0] p8;
        int          lat;

        vecs[0] = '{a: 4'd0,  b: 4'd0,  sgn: 1'b0, exp: 8'h00};
        vecs[1] = '{a: 4'd1,  b: 4'd1,  sgn: 1'b0, exp: 8'h01};
        vecs[2] = '{a: 4'd2,  b: 4'd8,  sgn: 1'b0, exp: 8'h10};
        vecs[3] = '{a: 4'd15, b: 4'd3,  sgn: 1'b0, exp: 8'h2D};
        vecs[4] = '{a: 4'd15, b: 4'd15, sgn: 1'b0, exp: 8'hE1};
        vecs[5] = '{a: 4'hF,  b: 4'hF,  sgn: 1'b1, exp: 8'h01};  // -1 * -1
        vecs[6] = '{a: 4'h8,  b: 4'h7,  sgn: 1'b1, exp: 8'hC8};  // -8 * 7
        vecs[7] = '{a: 4'h8,  b: 4'h8,  sgn: 1'b1, exp: 8'h40};  // -8 * -8
        vecs[8] = '{a: 4'h7,  b: 4'hD,  sgn: 1'b1, exp: 8'hEB};  // 7 * -3
        vecs[9] = '{a: 4'h0,  b: 4'hB,  sgn: 1'b1, exp: 8'h00};  // 0 * -5

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        ena = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; sgn4 = 1'b0; out_ready4 = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sgn8 = 1'b0; out_ready8 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready4), 32'd1);
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_product", 32'(product4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].sgn, p4, lat);
            check($sformatf("vec%0d_product", i), 32'(p4), 32'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
        end

        // Backpressure: hold the result for 6 cycles, pulse a new operand meanwhile.
        start4(4'd15, 4'd3, 1'b0);
        wait4(lat);
        check("bp_latency", 32'(lat), 32'd5);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                a4 = 4'd1;
                b4 = 4'd1;
                in_valid4 = 1'b1;
            end
            if (k == 3) begin
                in_valid4 = 1'b0;
            end
            check($sformatf("bp_hold%0d_product", k), 32'(product4), 32'd45);
            check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready4), 32'd0);
            check($sformatf("bp_hold%0d_out_valid", k), 32'(out_valid4), 32'd1);
        end
        ack4();
        check("bp_after_out_valid", 32'(out_valid4), 32'd0);
        check("bp_after_in_ready", 32'(in_ready4), 32'd1);
        check("bp_after_product_kept", 32'(product4), 32'd45);
        @(posedge clk);
        #1;
        check("bp_pulse_ignored_busy", 32'(busy4), 32'd0);

        // Output handshake and new operand in the same DONE cycle.
        start4(4'd2, 4'd8, 1'b0);
        wait4(lat);
        a4 = 4'd3;
        b4 = 4'd3;
        sgn4 = 1'b0;
        in_valid4 = 1'b1;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        check("coll_idle_in_ready", 32'(in_ready4), 32'd1);
        check("coll_idle_busy", 32'(busy4), 32'd0);
        check("coll_first_product", 32'(product4), 32'h10);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        check("coll_accept_busy", 32'(busy4), 32'd1);
        wait4(lat);
        check("coll_latency", 32'(lat), 32'd5);
        check("coll_product", 32'(product4), 32'd9);
        ack4();

        // Clock-enable stall of 3 cycles during CALC.
        start4(4'd15, 4'd15, 1'b0);
        @(posedge clk);
        #1;
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        check("stall_busy_frozen", 32'(busy4), 32'd1);
        ena = 1'b1;
        begin
            int more;
            wait4(more);
            lat = more + 4;
        end
        check("stall_latency", 32'(lat), 32'd8);
        check("stall_product", 32'(product4), 32'd225);
        ena = 1'b0;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        check("stall_no_handshake", 32'(out_valid4), 32'd1);
        ena = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        check("stall_handshake", 32'(out_valid4), 32'd0);

        // Asynchronous reset in the middle of CALC.
        start4(4'd15, 4'd15, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready4), 32'd1);
        check("midrst_out_valid", 32'(out_valid4), 32'd0);
        check("midrst_busy", 32'(busy4), 32'd0);
        check("midrst_product", 32'(product4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run4(4'd3, 4'd5, 1'b0, p4, lat);
        check("postrst_product", 32'(p4), 32'd15);
        check("postrst_latency", 32'(lat), 32'd5);

        // WIDTH=8 instance.
        run8(8'd255, 8'd255, 1'b0, p8, lat);
        check("w8_unsigned_product", 32'(p8), 32'hFE01);
        check("w8_unsigned_latency", 32'(lat), 32'd9);
        run8(8'h80, 8'h80, 1'b1, p8, lat);
        check("w8_signed_product", 32'(p8), 32'h4000);
        check("w8_signed_latency", 32'(lat), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq_shift_add.md
Name: mult_seq_shift_add

Overview:
Parametrised sequential shift-and-add multiplier. It replaces the fixed combinational 4x4 multiplier.
- Operands are WIDTH bits each; the product is 2*WIDTH bits.
- Each operation selects unsigned or two's-complement mode.
- Uses valid/ready handshakes on both input and output.
- Instantiated behind the Tiny Tapeout top wrapper, with WIDTH=4 for the pin-mapped build.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..16; product width is 2*WIDTH.

Ports:
clk        input   1          system clock, rising edge
rst_n      input   1          asynchronous active-low reset
ena        input   1          clock enable; when 0 all state holds, outputs unchanged
in_valid   input   1          operands a, b, sgn valid
in_ready   output  1          block can accept operands (1 only in IDLE)
a          input   WIDTH      multiplicand
b          input   WIDTH      multiplier
sgn        input   1          1 = operands two's complement, 0 = unsigned
out_valid  output  1          product valid (1 only in DONE)
out_ready  input   1          consumer accepts product
product    output  2*WIDTH    result, held stable while out_valid=1
busy       output  1          1 in CALC or FIX

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all datapath registers cleared.
  - Outputs: in_ready=1, out_valid=0, busy=0, product=0.
  - Reset is honoured in any state, including mid-CALC; the operation in flight is discarded with no partial output.
- All transitions below require ena=1; with ena=0 the FSM and datapath freeze and latency stretches by the stalled cycles.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1, latch operands into magnitudes:
    - sgn=0: ma=a, mb=b.
    - sgn=1: ma=|a|, mb=|b| as WIDTH-bit unsigned; the most-negative value -2^(WIDTH-1) maps to 2^(WIDTH-1), no overflow.
  - Latch neg = sgn & (a[MSB] ^ b[MSB]); acc=0; cnt=0; go to CALC.
- CALC:
  - One step per enabled cycle: if mb[cnt]=1 then acc <= acc + (ma << cnt); acc is 2*WIDTH bits, no carry loss. Then cnt <= cnt+1.
  - After step cnt=WIDTH-1, go to FIX. Exactly WIDTH steps; no early termination on zero operands.
- FIX: product <= neg ? (~acc + 1) : acc; go to DONE.
- DONE:
  - out_valid=1; product held.
  - On edge with out_ready=1 (and ena=1), go to IDLE; out_valid drops the next cycle.
  - in_valid is ignored while not in IDLE.
- Latency: with accept edge E0 and ena held 1, out_valid=1 after edge E0+WIDTH+1. For WIDTH=4 that is 5 cycles.
- Throughput: one result per WIDTH+3 cycles minimum; IDLE is re-entered for one cycle before the next accept.
- product is not cleared on leaving DONE; it keeps the last result until the next FIX. Only out_valid qualifies it.
- Zero operands still run the full WIDTH steps and return product=0; in signed mode with neg=1 the negation of 0 is 0.
- Simultaneous events:
  - out_ready and in_valid in the same DONE cycle: only the output handshake completes. The input is accepted no earlier than the following IDLE cycle.
  - ena=0 while out_ready=1 in DONE: no handshake.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, CALC, FIX, DONE}.
  - Function abs_mag(value, sgn) returning the WIDTH-bit magnitude.
  - Constant MAX_WIDTH=16.
- One sub-module, mult_seq_datapath: magnitude capture, accumulator, shift/add, counter, final negation.
  - Controlled by load/step/fix strobes from the FSM in mult_seq_shift_add.
  - Returns last_step to the FSM.

Test Plan:
- WIDTH=4, sgn=0, pairs (0,0),(1,1),(2,8),(15,3),(15,15): product 0, 1, 16, 45, 225 (0xE1). out_valid exactly 5 cycles after accept.
- WIDTH=4, sgn=1: (-1,-1) -> 0x01; (-8,7) -> 0xC8 (-56); (-8,-8) -> 0x40 (64); (7,-3) -> 0xEB (-21); (0,-5) -> 0x00.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid. product stays 45, in_ready=0. A new in_valid pulse is ignored; the first result is unchanged after out_ready=1.
- Stall: drop ena for 3 cycles during CALC on 15x15. out_valid appears at 8 cycles instead of 5; product=225.
- Reset mid-op: assert rst_n=0 at CALC step 2 (asynchronous, between edges). in_ready=1, out_valid=0 and product=0 immediately. The next op 3x5 returns 15.
- WIDTH=8, sgn=0: 255x255 -> 0xFE01, out_valid 9 cycles after accept. With sgn=1, -128x-128 -> 0x4000.
